// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: reset PC, inter-stage bus widths and the IF->ID bus layout.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
  localparam int          FS_TO_DS_BUS_WD = 65;
  localparam int          BR_BUS_WD       = 33;

  localparam int FS_BUS_ADEF_BIT = 64;
  localparam int FS_BUS_PC_LSB   = 32;
  localparam int FS_BUS_INST_LSB = 0;

  // A misaligned fetch carries no usable instruction word, so it is zeroed on the bus.
  function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_to_ds(input logic        adef,
                                                               input logic [31:0] pc,
                                                               input logic [31:0] inst);
    logic [FS_TO_DS_BUS_WD-1:0] bus;
    bus                          = '0;
    bus[FS_BUS_ADEF_BIT]         = adef;
    bus[FS_BUS_PC_LSB +: 32]     = pc;
    bus[FS_BUS_INST_LSB +: 32]   = adef ? 32'h0 : inst;
    return bus;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// IF-stage bus bundle: IF->ID handshake, branch redirect from decode, instruction SRAM port.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                       ds_allowin;
  logic                       br_taken;
  logic [31:0]                br_target;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin, br_taken, br_target, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_taken, br_target, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/if_inst_buf.sv
// Holds an SRAM read word across decode back-pressure, since rdata is only valid one cycle.
module if_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] inst,
  output logic        buf_valid
);

  logic [31:0] inst_buf;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      inst_buf <= rdata;
    end
  end

  assign inst = buf_valid ? inst_buf : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC select, SRAM request and IF->ID handshake.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
module if_stage #(
  parameter logic [31:0] RESET_PC        = if_stage_pkg::RESET_PC,
  parameter int          FS_TO_DS_BUS_WD = if_stage_pkg::FS_TO_DS_BUS_WD
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  fs
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  import if_stage_pkg::*;

  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       br_taken;
  logic [31:0]                br_target;
  logic                       to_fs_valid;
  logic                       fs_ready_go;
  logic                       fs_allowin;
  logic [31:0]                seq_pc;
  logic [31:0]                nextpc;
  logic                       fs_valid;
  logic                       fs_adef;
  logic [31:0]                fs_pc;
  logic [31:0]                fs_inst;
  logic                       fs_to_ds_valid;
  logic                       ds_handshake;
  logic                       buf_capture;
  logic                       buf_clear;
  logic                       buf_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_bus;

  assign br_bus                = {fs.br_taken, fs.br_target};
  assign {br_taken, br_target} = br_bus;

  // Pre-IF: select the next fetch address and request it from the SRAM
  assign to_fs_valid = ~reset;
  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br_taken ? br_target : seq_pc;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & fs.ds_allowin) | br_taken;

  assign fs.inst_sram_en    = to_fs_valid & fs_allowin;
  assign fs.inst_sram_we    = 4'b0;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_wdata = 32'b0;

  // IF: the PC is registered here; its instruction word arrives from the SRAM this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
      fs_adef  <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      fs_pc    <= nextpc;
      fs_adef  <= |nextpc[1:0];
    end
  end

  assign fs_to_ds_valid = ~reset & fs_valid & fs_ready_go & ~br_taken;
  assign ds_handshake   = fs_to_ds_valid & fs.ds_allowin;
  assign buf_capture    = fs_valid & ~fs.ds_allowin & ~buf_valid & ~br_taken;
  assign buf_clear      = ds_handshake | br_taken;

  if_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (buf_capture),
    .clear     (buf_clear),
    .rdata     (fs.inst_sram_rdata),
    .inst      (fs_inst),
    .buf_valid (buf_valid)
  );

  assign fs_bus            = pack_fs_to_ds(fs_adef, fs_pc, fs_inst);
  assign fs.fs_to_ds_bus   = fs_bus;
  assign fs.fs_to_ds_valid = fs_to_ds_valid;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (ds_handshake) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (!fs_to_ds_valid) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus a randomized run against an instruction-stream model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Reference model: which instruction (if any) IF currently holds, plus counters
  bit          m_valid;
  logic [31:0] m_pc;
  int unsigned m_fetch;
  int unsigned m_bubble;

  if_stage_if ifc ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (ifc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0421;
    return (a * 32'h9e37_79b1) ^ 32'h1357_2468;
  endfunction

  // Synchronous SRAM; when not requested it returns junk so only a held copy survives a stall
  always @(posedge clk) begin
    ifc.inst_sram_rdata <= ifc.inst_sram_en ? mem(ifc.inst_sram_addr) : $urandom();
  end

  function automatic logic [64:0] exp_bus(input logic [31:0] pc);
    logic adef;
    adef = (pc[1:0] != 2'b00);
    return {adef, pc, adef ? 32'h0 : mem(pc)};
  endfunction

  function automatic logic exp_valid();
    return !reset && m_valid && !ifc.br_taken;
  endfunction

  function automatic logic exp_en();
    return !reset && (!m_valid || ifc.ds_allowin || ifc.br_taken);
  endfunction

  function automatic logic [31:0] exp_addr();
    if (ifc.br_taken) return ifc.br_target;
    return m_valid ? m_pc + 32'd4 : RST_PC;
  endfunction

  task automatic set_in(input logic rst, input logic ds, input logic br, input logic [31:0] tgt);
    reset          = rst;
    ifc.ds_allowin = ds;
    ifc.br_taken   = br;
    ifc.br_target  = tgt;
    #1;
  endtask

  // Advance the model by the cycle whose inputs are currently applied, then cross the clock edge
  task automatic tick();
    logic [31:0] a;
    logic        v;
    a = exp_addr();
    v = exp_valid();
    if (reset) begin
      m_valid  = 1'b0;
      m_fetch  = 0;
      m_bubble = 0;
    end else begin
      if (v && ifc.ds_allowin) m_fetch++;
      if (!v) m_bubble++;
      if (!m_valid || ifc.ds_allowin || ifc.br_taken) begin
        m_valid = 1'b1;
        m_pc    = a;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", ifc.fs_to_ds_valid);
    end
    n_checks++;
    if (ifc.inst_sram_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en: got %b want 0", ifc.inst_sram_en);
    end
    tick();
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_bubble_cnt);
    end
`endif
  endtask

  task automatic test_first_fetch();
    logic [64:0] want;
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1c00_0000) begin
      n_fail++; $display("FAIL first_req: got en=%b addr=%h want en=1 addr=1c000000", ifc.inst_sram_en, ifc.inst_sram_addr);
    end
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_valid0: got %b want 0", ifc.fs_to_ds_valid);
    end
    n_checks++;
    if (ifc.inst_sram_we !== 4'b0 || ifc.inst_sram_wdata !== 32'b0) begin
      n_fail++; $display("FAIL sram_tie: got we=%h wdata=%h want 0/0", ifc.inst_sram_we, ifc.inst_sram_wdata);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    want = {1'b0, 32'h1c00_0000, 32'h0280_0421};
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== want) begin
      n_fail++; $display("FAIL first_bus: got v=%b bus=%h want v=1 bus=%h", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, want);
    end
    n_checks++;
    if (ifc.inst_sram_addr !== 32'h1c00_0004) begin
      n_fail++; $display("FAIL first_next: got %h want 1c000004", ifc.inst_sram_addr);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [64:0] want;
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    want = exp_bus(32'h1c00_0008);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== want) begin
        n_fail++; $display("FAIL stall_bus[%0d]: got v=%b bus=%h want v=1 bus=%h", i, ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, want);
      end
      n_checks++;
      if (ifc.inst_sram_en !== 1'b0 || ifc.inst_sram_addr !== 32'h1c00_000c) begin
        n_fail++; $display("FAIL stall_req[%0d]: got en=%b addr=%h want en=0 addr=1c00000c", i, ifc.inst_sram_en, ifc.inst_sram_addr);
      end
      tick();
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== want || ifc.inst_sram_en !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got v=%b en=%b bus=%h want v=1 en=1 bus=%h", ifc.fs_to_ds_valid, ifc.inst_sram_en, ifc.fs_to_ds_bus, want);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_bus !== exp_bus(32'h1c00_000c)) begin
      n_fail++; $display("FAIL stall_once: got %h want %h", ifc.fs_to_ds_bus, exp_bus(32'h1c00_000c));
    end
    tick();
  endtask

  task automatic test_branch();
    set_in(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
    n_checks++;
    if (ifc.fs_to_ds_bus[63:32] !== 32'h1c00_0010) begin
      n_fail++; $display("FAIL br_pre_pc: got %h want 1c000010", ifc.fs_to_ds_bus[63:32]);
    end
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1c00_0100) begin
      n_fail++; $display("FAIL br_cancel: got v=%b en=%b addr=%h want v=0 en=1 addr=1c000100", ifc.fs_to_ds_valid, ifc.inst_sram_en, ifc.inst_sram_addr);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== exp_bus(32'h1c00_0100)) begin
      n_fail++; $display("FAIL br_target_bus: got v=%b bus=%h want v=1 bus=%h", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, exp_bus(32'h1c00_0100));
    end
    tick();
  endtask

  task automatic test_branch_stall_buf();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== exp_bus(32'h1c00_0104)) begin
      n_fail++; $display("FAIL bsb_held: got v=%b bus=%h want v=1 bus=%h", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, exp_bus(32'h1c00_0104));
    end
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h1c00_0200);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1c00_0200) begin
      n_fail++; $display("FAIL bsb_redirect: got v=%b en=%b addr=%h want v=0 en=1 addr=1c000200", ifc.fs_to_ds_valid, ifc.inst_sram_en, ifc.inst_sram_addr);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== exp_bus(32'h1c00_0200)) begin
      n_fail++; $display("FAIL bsb_fresh: got v=%b bus=%h want v=1 bus=%h", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, exp_bus(32'h1c00_0200));
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_bus !== exp_bus(32'h1c00_0204)) begin
      n_fail++; $display("FAIL bsb_next: got %h want %h", ifc.fs_to_ds_bus, exp_bus(32'h1c00_0204));
    end
    tick();
  endtask

  task automatic test_misaligned();
    set_in(1'b0, 1'b1, 1'b1, 32'h1c00_0102);
    n_checks++;
    if (ifc.inst_sram_addr !== 32'h1c00_0102 || ifc.inst_sram_en !== 1'b1) begin
      n_fail++; $display("FAIL mis_req: got en=%b addr=%h want en=1 addr=1c000102", ifc.inst_sram_en, ifc.inst_sram_addr);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {1'b1, 32'h1c00_0102, 32'h0}) begin
      n_fail++; $display("FAIL mis_bus: got v=%b bus=%h want v=1 bus=%h", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, {1'b1, 32'h1c00_0102, 32'h0});
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_bus !== {1'b1, 32'h1c00_0106, 32'h0}) begin
      n_fail++; $display("FAIL mis_stall: got %h want %h", ifc.fs_to_ds_bus, {1'b1, 32'h1c00_0106, 32'h0});
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall_out: got v=%b en=%b want 0/0", ifc.fs_to_ds_valid, ifc.inst_sram_en);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1c00_0000) begin
      n_fail++; $display("FAIL rst_restart: got v=%b en=%b addr=%h want v=0 en=1 addr=1c000000", ifc.fs_to_ds_valid, ifc.inst_sram_en, ifc.inst_sram_addr);
    end
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_bubble_cnt);
    end
`endif
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {1'b0, 32'h1c00_0000, 32'h0280_0421}) begin
      n_fail++; $display("FAIL rst_first: got v=%b bus=%h want v=1 bus=%h", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus, {1'b0, 32'h1c00_0000, 32'h0280_0421});
    end
    tick();
  endtask

  task automatic test_random();
    logic        rst, ds, br;
    logic [31:0] tgt;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      ds  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 5) == 0);
      tgt = {16'h1c00, 16'($urandom())};
      if ($urandom_range(0, 4) != 0) tgt[1:0] = 2'b00;
      set_in(rst, ds, br, tgt);
      n_checks++;
      if (ifc.fs_to_ds_valid !== exp_valid()) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, ifc.fs_to_ds_valid, exp_valid());
      end
      if (exp_valid()) begin
        n_checks++;
        if (ifc.fs_to_ds_bus !== exp_bus(m_pc)) begin
          n_fail++; $display("FAIL rnd_bus[%0d]: got %h want %h", i, ifc.fs_to_ds_bus, exp_bus(m_pc));
        end
      end
      n_checks++;
      if (ifc.inst_sram_en !== exp_en()) begin
        n_fail++; $display("FAIL rnd_en[%0d]: got %b want %b", i, ifc.inst_sram_en, exp_en());
      end
      if (!rst) begin
        n_checks++;
        if (ifc.inst_sram_addr !== exp_addr()) begin
          n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, ifc.inst_sram_addr, exp_addr());
        end
      end
`ifdef IF_PERF_CNT_EN
      n_checks++;
      if (perf_fetch_cnt !== m_fetch || perf_bubble_cnt !== m_bubble) begin
        n_fail++; $display("FAIL rnd_perf[%0d]: got %0d/%0d want %0d/%0d", i, perf_fetch_cnt, perf_bubble_cnt, m_fetch, m_bubble);
      end
`endif
      tick();
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    m_valid           = 1'b0;
    m_pc              = 32'h0;
    m_fetch           = 0;
    m_bubble          = 0;
    reset             = 1'b1;
    ifc.ds_allowin    = 1'b0;
    ifc.br_taken      = 1'b0;
    ifc.br_target     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch();
    test_branch_stall_buf();
    test_misaligned();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined LoongArch32 core; sits directly upstream of decode (ID).
- Owns the PC and the pre-IF next-PC selection, and drives the synchronous instruction SRAM (1-cycle read latency).
- Delivers {pc, inst, adef} to decode over a valid/allowin handshake.
- Redirects the PC on branches resolved in decode and keeps the fetched instruction alive across decode back-pressure.

Parameters:
- RESET_PC, 32'h1c00_0000, address of the first fetched instruction.
- FS_TO_DS_BUS_WD, 65, width of the stage bus to decode: {adef, pc, inst}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  decode can accept a new instruction this cycle
- br_taken  in  1  single-cycle pulse: decode resolved a taken branch/jump
- br_target  in  32  redirect address, qualified by br_taken
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction
- fs_to_ds_bus  out  65  {adef[64], pc[63:32], inst[31:0]}
- inst_sram_en  out  1  read request
- inst_sram_we  out  4  tied 4'b0
- inst_sram_addr  out  32  read address = nextpc
- inst_sram_wdata  out  32  tied 32'b0
- inst_sram_rdata  in  32  read data, valid the cycle after the request

Behaviour:
Reset (clk = clk, reset = reset: synchronous, active-high)
- fs_valid=0, fs_pc=RESET_PC-4, inst_buf_valid=0.
- Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0.

Pre-IF
- to_fs_valid = ~reset.
- seq_pc = fs_pc + 4, 32-bit wrap.
- nextpc = br_taken ? br_target : seq_pc.
- fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
- inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc.
- First request is issued in the cycle reset deasserts, at addr 0x1c00_0000.

IF register update (each cycle with fs_allowin=1)
- fs_valid <= to_fs_valid; fs_pc <= nextpc; adef <= |nextpc[1:0].
- If fs_allowin=0, all IF state holds.

Ready and output
- fs_ready_go = 1: a fetch always completes in 1 cycle.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.

Branch cancel
- A br_taken pulse invalidates the instruction currently in IF; it never reaches decode.
- In the same cycle, br_target is issued to the SRAM.
- IF holds br_target with valid data the following cycle.
- br_taken while fs_valid=0 simply redirects.

Instruction buffer
- Needed because rdata is only guaranteed the cycle after a request.
- Capture: fs_valid & ~ds_allowin & ~inst_buf_valid & ~br_taken -> inst_buf <= rdata, inst_buf_valid <= 1.
- Output inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Clear inst_buf_valid on handshake (fs_to_ds_valid & ds_allowin), on br_taken, or on reset.

Misaligned fetch
- adef=1 when pc[1:0] != 0.
- inst is forced to 32'h0 in the bus; the instruction is still delivered valid.
- Decode/WB raise ADEF.

Reset asserted mid-stall or mid-branch: all state returns to reset values next cycle; the buffer is dropped.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each completed IF->ID handshake.
  - perf_bubble_cnt increments each cycle with ~reset & ~fs_to_ds_valid.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FS_TO_DS_BUS_WD, BR_BUS_WD=33, RESET_PC, bus field offsets. The other stages' bus widths live there too.
- Sub-module if_inst_buf holds the capture/select logic (buffer + valid flag). It is the natural reusable piece; the rest stays flat.

Test Plan:
- Reset release, ds_allowin=1, SRAM returns 0x02800421 at 0x1c000000 -> cycle 1 bus = {0, 0x1c000000, 0x02800421}, valid=1; next addr 0x1c000004.
- ds_allowin=0 for 3 cycles while pc=0x1c000008; SRAM rdata changed to garbage after cycle 1 -> bus inst holds original word; en=0, addr stable; delivered once when ds_allowin returns.
- br_taken=1, br_target=0x1c000100 while IF holds pc=0x1c000010 -> fs_to_ds_valid=0 that cycle, addr=0x1c000100; next cycle bus pc=0x1c000100.
- br_taken coinciding with ds_allowin=0 and a full buffer -> buffer cleared; redirect issued; the stale instruction is never seen by decode.
- br_target=0x1c000102 -> bus adef=1, inst=0, pc=0x1c000102, valid=1.
- Reset asserted during a stall -> fs_to_ds_valid=0 next cycle; after release, fetch restarts at 0x1c000000. With IF_PERF_CNT_EN, both counters read 0 after reset.
